// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-to-word receive stage.
package deser_pkg;

  // Frame FSM states: waiting for a start bit, collecting data bits, checking stop bit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Level the serial line rests at between frames; the opposite level marks a start bit.
  localparam logic IDLE_LEVEL = 1'b1;

  // Bit counter width: wide enough to reach DATA_W without wrapping inside a frame.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Strobe-enabled data-bit counter with synchronous clear and a flag that marks
// the strobe carrying the final data bit.
module bit_counter
  import deser_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic             clk,
  input  logic             re,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  // Clear has priority over counting so a start bit always restarts from zero.
  always_ff @(posedge clk) begin
    if (re) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High while the counter points at the last data bit position.
  always_comb begin
    last = (cnt == CNT_W'(DATA_W - 1));
  end

endmodule

// File: rtl/bit_deserializer.sv
// Frames a strobed serial bit stream (start, DATA_W data bits LSB first, stop)
// into words. A good stop bit produces a one-cycle valid pulse with the word on
// data; a bad stop bit produces a one-cycle frame_err pulse and data is kept.
//
// Handshake: there is no back-pressure. din is consumed only on cycles with
// din_en=1; valid (or frame_err) is a single-cycle pulse the consumer must
// capture, and data stays stable until the next valid.
module bit_deserializer
  import deser_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              re,
  input  logic              din,
  input  logic              din_en,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t             state;
  state_t             state_d;
  logic [DATA_W-1:0]  shift_q;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic               start_hit;
  logic               data_hit;
  logic               stop_hit;

  // A start bit is only recognised in IDLE; a bad stop bit never doubles as one.
  always_comb begin
    start_hit = (state == IDLE) && din_en && (din != IDLE_LEVEL);
    data_hit  = (state == DATA) && din_en;
    stop_hit  = (state == STOP) && din_en;
  end

  bit_counter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .re   (re),
    .clr  (start_hit),
    .en   (data_hit),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (re) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; unstrobed cycles leave the state unchanged.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_hit) state_d = DATA;
      DATA:    if (data_hit && cnt_last) state_d = STOP;
      STOP:    if (stop_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each data strobe writes its bit into the position named by the counter.
  always_ff @(posedge clk) begin
    if (re) begin
      shift_q <= '0;
    end else if (data_hit) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (cnt == CNT_W'(i)) shift_q[i] <= din;
      end
    end
  end

  // Output registers: pulses last one cycle, busy tracks the frame in progress.
  always_ff @(posedge clk) begin
    if (re) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= (state_d != IDLE);
      if (stop_hit) begin
        if (din == IDLE_LEVEL) begin
          data  <= shift_q;
          valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_deserializer.sv
// Randomised bench for bit_deserializer: a driver issues strobed frames and
// feeds a bit-list reference model; a negedge monitor compares DUT pulses
// against the expected queue and checks busy/data every cycle.
module tb_bit_deserializer;

  localparam int DATA_W = 8;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] word;
    int                due;
  } exp_t;

  logic              clk;
  logic              re;
  logic              din;
  logic              din_en;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              frame_err;
  logic              busy;

  exp_t              exp_q[$];
  exp_t              head;
  logic              bits_q[$];
  logic              model_busy;
  logic [DATA_W-1:0] model_data;
  int                cyc;
  int                n_checks;
  int                n_pass;
  logic              mon_en;

  bit_deserializer #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .re        (re),
    .din       (din),
    .din_en    (din_en),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Clock and reset-time defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // One clock of stimulus, then advance the reference model by that clock edge.
  task automatic step(input logic rst, input logic en, input logic d);
    logic [DATA_W-1:0] w;
    re = rst; din_en = en; din = d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_busy = 1'b0;
      model_data = '0;
      bits_q.delete();
    end else if (en) begin
      if (!model_busy) begin
        if (d == 1'b0) begin
          model_busy = 1'b1;
          bits_q.delete();
        end
      end else begin
        bits_q.push_back(d);
        if (bits_q.size() == DATA_W + 1) begin
          w = '0;
          for (int i = 0; i < DATA_W; i++) w = w + (DATA_W'(bits_q[i]) << i);
          if (bits_q[DATA_W]) begin
            exp_q.push_back('{err: 1'b0, word: w, due: cyc});
            model_data = w;
          end else begin
            exp_q.push_back('{err: 1'b1, word: model_data, due: cyc});
          end
          model_busy = 1'b0;
          bits_q.delete();
        end
      end
    end
    #1;
  endtask

  // Strobe one bit after a random number of idle (unstrobed, noisy) cycles.
  task automatic strobe(input logic b, input int gmin, input int gmax);
    repeat ($urandom_range(gmin, gmax)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1, b);
  endtask

  // Full frame; abort_at >= 0 asserts reset in place of that data bit.
  task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop,
                            input int gmin, input int gmax, input int abort_at);
    strobe(1'b0, gmin, gmax);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == abort_at) begin
        step(1'b1, 1'b0, 1'b1);
        return;
      end
      strobe(w[i], gmin, gmax);
    end
    strobe(stop, gmin, gmax);
  endtask

  // Monitor: every cycle check busy/data, and pop the scoreboard on each pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", {31'd0, busy}, {31'd0, model_busy});
      check("data_hold", 32'(data), 32'(model_data));
      check("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          head = exp_q.pop_front();
          check("pulse_cycle", cyc, head.due);
          check("pulse_kind", {31'd0, frame_err}, {31'd0, head.err});
          check("word", 32'(data), 32'(head.word));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        head = exp_q.pop_front();
        check("missing_pulse", {31'd0, head.err}, {31'd0, ~head.err});
      end
    end
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; mon_en = 1'b0;
    model_busy = 1'b0; model_data = '0;
    re = 1'b1; din = 1'b1; din_en = 1'b0;

    // Reset, with din_en active to show reset has priority.
    step(1'b1, 1'b1, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", 32'(data), 32'd0);
    repeat (3) step(1'b0, 1'b1, 1'b1);

    // Good frame 0xA5 with a strobe every cycle.
    send_frame(8'hA5, 1'b1, 0, 0, -1);
    repeat (2) step(1'b0, 1'b1, 1'b1);

    // 0x3C with a bad stop bit: frame_err, data keeps 0xA5.
    send_frame(8'h3C, 1'b0, 0, 0, -1);
    repeat (2) step(1'b0, 1'b1, 1'b1);

    // Line low without strobes, then idle strobes: nothing should start.
    repeat (5) step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1);

    // Abort 0xFF after four data bits, then a clean 0x3C.
    send_frame(8'hFF, 1'b1, 0, 0, 4);
    step(1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 0, 0, -1);

    // Back-to-back 0x01 and 0xFE, one strobe in four.
    send_frame(8'h01, 1'b1, 3, 3, -1);
    send_frame(8'hFE, 1'b1, 3, 3, -1);
    repeat (4) step(1'b0, 1'b0, 1'b1);

    // Random frames: random spacing, stop bits, idle strobes and occasional aborts.
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b1, 1'b1);
      send_frame(DATA_W'($urandom), ($urandom_range(0, 3) != 0), 0, $urandom_range(0, 3),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(0, DATA_W - 1) : -1);
    end

    repeat (4) step(1'b0, 1'b0, 1'b1);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
